// File: rtl/ifu_fetch_if.sv
// Fetch unit bus: request/response to instruction memory, instruction handoff to decode,
// and redirect input from execute. master = fetch unit, slave = its environment.
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 64
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [31:0]           inst;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  fetch_fault;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc, fetch_fault,
        output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: credit-based in-order fetch, response FIFO, redirect squash.
// Optional misaligned-target fault when FETCH_MISALIGN_CHK_EN is defined.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 64'h8000_0000,
    parameter int                    FIFO_DEPTH      = 2,
    parameter int                    MAX_OUTSTANDING = 2
) (
    input logic         clk,
    input logic         rst_n,
    ifu_fetch_if.master bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [CNT_W-1:0]      fifo_count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [OUT_W-1:0]      outstanding;
    logic [OUT_W-1:0]      drop_cnt;
    logic                  fetch_en;
    logic                  fault_q;

    logic [31:0]           inst_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] tgt_pc;
    logic                  misalign;
    logic [SUM_W-1:0]      credit_used;
    logic                  inst_valid;
    logic                  redirect;
    logic                  req_fire;
    logic                  resp_dec;
    logic                  resp_take;
    logic                  resp_drop;
    logic                  pop;
    logic [OUT_W-1:0]      out_after_resp;

`ifdef FETCH_MISALIGN_CHK_EN
    assign tgt_pc   = bus.redirect_pc;
    assign misalign = |bus.redirect_pc[1:0];
`else
    assign tgt_pc   = bus.redirect_pc & ~ADDR_WIDTH'(3);
    assign misalign = 1'b0;
`endif

    assign redirect = bus.redirect_valid;

    // Slots already claimed: buffered words plus responses still to be kept.
    assign credit_used = SUM_W'(fifo_count) + SUM_W'(outstanding) - SUM_W'(drop_cnt);

    assign bus.req_valid = fetch_en && !redirect && !fault_q &&
                           (outstanding < OUT_W'(MAX_OUTSTANDING)) &&
                           (credit_used < SUM_W'(FIFO_DEPTH));
    assign bus.req_addr  = fetch_pc;

    assign req_fire  = bus.req_valid && bus.req_ready;
    assign resp_dec  = bus.resp_valid && (outstanding != '0);
    assign resp_take = bus.resp_valid && !redirect && (drop_cnt == '0);
    assign resp_drop = bus.resp_valid && !redirect && (drop_cnt != '0);

    assign inst_valid      = (fifo_count != '0);
    assign pop             = inst_valid && bus.inst_ready && !redirect;
    assign out_after_resp  = outstanding - OUT_W'(resp_dec);

    assign bus.inst_valid  = inst_valid;
    assign bus.inst        = inst_valid ? inst_mem[rd_ptr] : '0;
    assign bus.inst_pc     = inst_valid ? pc_mem[rd_ptr]   : '0;
    assign bus.fetch_fault = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_en    <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fault_q     <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            if (redirect) begin
                // Every response still in flight after this cycle belongs to the old path.
                fetch_pc    <= tgt_pc;
                resp_pc     <= tgt_pc;
                fifo_count  <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                outstanding <= out_after_resp;
                drop_cnt    <= out_after_resp;
                if (misalign) begin
                    fault_q <= 1'b1;
                end
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
                end
                outstanding <= out_after_resp + OUT_W'(req_fire);
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - OUT_W'(1);
                end
                if (resp_take) begin
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                    resp_pc <= resp_pc + ADDR_WIDTH'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                fifo_count <= fifo_count + CNT_W'(resp_take) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resp_take) begin
            inst_mem[wr_ptr] <= bus.resp_data;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a 1-cycle in-order memory model that can be held.
module tb_ifu_fetch;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic clk;
    logic rst_n;
    logic mem_hold;
    int   total;
    int   bad;
    logic [63:0] exp_pc;
    logic [63:0] mq [$];

    ifu_fetch_if #(.ADDR_WIDTH(64)) bus ();

    ifu_fetch #(
        .ADDR_WIDTH(64),
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(2),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory: sample accepted requests mid-cycle, answer one per cycle just after the edge.
    always begin
        @(negedge clk);
        #4;
        if (!rst_n) mq.delete();
        else if (bus.req_valid && bus.req_ready) mq.push_back(bus.req_addr);
        @(posedge clk);
        #2;
        if (!rst_n || mem_hold || mq.size() == 0) begin
            bus.resp_valid = 1'b0;
        end else begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = memf(mq.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_next(input string tag);
        int n;
        n = 0;
        while (!bus.inst_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, {63'd0, bus.inst_valid}, 64'd1);
        chk({tag, "_pc"}, bus.inst_pc, exp_pc);
        chk({tag, "_data"}, {32'd0, bus.inst}, {32'd0, memf(exp_pc)});
        exp_pc = exp_pc + 64'd4;
        tick();
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        #1;
        chk("redir_req_valid", {63'd0, bus.req_valid}, 64'd0);
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        mem_hold = 1'b0;
        bus.req_ready      = 1'b0;
        bus.resp_valid     = 1'b0;
        bus.resp_data      = 32'd0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        exp_pc = RESET_PC;
        repeat (2) @(negedge clk);

        chk("rst_req_valid", {63'd0, bus.req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        chk("rst_inst", {32'd0, bus.inst}, 64'd0);
        chk("rst_inst_pc", bus.inst_pc, 64'd0);
        chk("rst_fault", {63'd0, bus.fetch_fault}, 64'd0);
        chk("rst_req_addr", bus.req_addr, RESET_PC);

        // Request held by memory: address must stay put.
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", {63'd0, bus.req_valid}, 64'd1);
            chk("stall_req_addr", bus.req_addr, RESET_PC);
            tick();
        end

        // Test 1: in-order stream from reset PC.
        bus.req_ready  = 1'b1;
        bus.inst_ready = 1'b1;
        repeat (6) expect_next("t1");

        // Test 2: decoder stall fills the buffer, then resumes without gaps.
        bus.inst_ready = 1'b0;
        repeat (10) tick();
        chk("t2_count", {62'd0, dut.fifo_count}, 64'd2);
        chk("t2_req_valid", {63'd0, bus.req_valid}, 64'd0);
        chk("t2_outstanding", {62'd0, dut.outstanding}, 64'd0);
        chk("t2_head_pc", bus.inst_pc, exp_pc);
        bus.inst_ready = 1'b1;
        repeat (4) expect_next("t2");

        // Test 3: two requests in flight when redirected.
        mem_hold = 1'b1;
        repeat (6) tick();
        chk("t3_outstanding", {62'd0, dut.outstanding}, 64'd2);
        chk("t3_req_valid", {63'd0, bus.req_valid}, 64'd0);
        chk("t3_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        redirect_to(64'h8000_0100);
        chk("t3_drop_cnt", {62'd0, dut.drop_cnt}, 64'd2);
        chk("t3_flushed", {63'd0, bus.inst_valid}, 64'd0);
        mem_hold = 1'b0;
        exp_pc = 64'h8000_0100;
        repeat (2) expect_next("t3");
        chk("t3_drop_zero", {62'd0, dut.drop_cnt}, 64'd0);

        // Test 4: redirect while a response and a pop happen together.
        n = 0;
        while (!(bus.resp_valid && bus.inst_valid) && n < 20) begin
            tick();
            n++;
        end
        chk("t4_found", {63'd0, bus.resp_valid && bus.inst_valid}, 64'd1);
        redirect_to(64'h8000_0180);
        chk("t4_flushed", {63'd0, bus.inst_valid}, 64'd0);
        exp_pc = 64'h8000_0180;
        repeat (2) expect_next("t4");

        // Test 5: back-to-back redirects, last one wins.
        redirect_to(64'h8000_0200);
        redirect_to(64'h8000_0300);
        chk("t5_flushed", {63'd0, bus.inst_valid}, 64'd0);
        exp_pc = 64'h8000_0300;
        repeat (3) expect_next("t5");

        // Test 6: misaligned redirect target.
        redirect_to(64'h8000_0102);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_fault", {63'd0, bus.fetch_fault}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t6_req_blocked", {63'd0, bus.req_valid}, 64'd0);
            tick();
        end
        chk("t6_no_inst", {63'd0, bus.inst_valid}, 64'd0);
        chk("t6_fault_sticky", {63'd0, bus.fetch_fault}, 64'd1);
`else
        chk("t6_fault", {63'd0, bus.fetch_fault}, 64'd0);
        exp_pc = 64'h8000_0100;
        repeat (2) expect_next("t6");
`endif

        // Reset in the middle of operation.
        rst_n = 1'b0;
        #1;
        chk("mrst_req_valid", {63'd0, bus.req_valid}, 64'd0);
        chk("mrst_inst_valid", {63'd0, bus.inst_valid}, 64'd0);
        chk("mrst_fault", {63'd0, bus.fetch_fault}, 64'd0);
        chk("mrst_req_addr", bus.req_addr, RESET_PC);
        tick();
        rst_n = 1'b1;
        exp_pc = RESET_PC;
        repeat (3) expect_next("mrst");

        // PC wraps past the top of the address space.
        redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
        exp_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        repeat (4) expect_next("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
